// File: rtl/aes_enc_feeder.sv
// aes_enc_feeder: FIFO-fed launcher for aes_encipher_block with a tagged valid/ready result register
module aes_enc_feeder #(
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  input  logic [TAG_W-1:0] in_tag,
  output logic             enc_next,
  output logic [127:0]     enc_block,
  input  logic             enc_ready,
  input  logic [127:0]     enc_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [31:0]      blocks_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t           state;
  logic [127:0]     blk_mem [FIFO_DEPTH];
  logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wait_first, push, pop, launch;
  assign in_ready  = count != (AW+1)'(FIFO_DEPTH);
  assign push      = in_valid && in_ready;
  assign launch    = state == IDLE && count != '0 && key_ready && enc_ready;
  assign pop       = state == WAIT && !wait_first && enc_ready && (!out_valid || out_ready);
  assign enc_block = blk_mem[rd_ptr];
  assign busy      = state != IDLE || count != '0;
  // FIFO storage; the head stays put until its result is captured
  always_ff @(posedge clk) begin
    if (push) begin
      blk_mem[wr_ptr] <= in_block;
      tag_mem[wr_ptr] <= in_tag;
    end
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // launch FSM; the first WAIT cycle is skipped because the cipher drops ready late
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      enc_next   <= 1'b0;
      wait_first <= 1'b0;
    end else begin
      enc_next   <= launch;
      wait_first <= state == START;
      state      <= launch ? START : state == START ? WAIT : pop ? IDLE : state;
    end
  end
  // result register and completion counter
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_block   <= '0;
      out_tag     <= '0;
      blocks_done <= '0;
    end else if (pop) begin
      out_valid   <= 1'b1;
      out_block   <= enc_result;
      out_tag     <= tag_mem[rd_ptr];
      blocks_done <= blocks_done + 32'd1;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end
endmodule
